// File: rtl/kws_pkg.sv
// kws_pkg: opcode, status and sequencer state definitions shared by the
// command sequencer and its FIFO.
package kws_pkg;

   // Layer opcodes understood by the layer-control FSM
   localparam logic [3:0] OP_CMVN       = 4'h3;
   localparam logic [3:0] OP_CNN        = 4'h4;
   localparam logic [3:0] OP_RELU       = 4'h5;
   localparam logic [3:0] OP_BATCH_NORM = 4'h6;
   localparam logic [3:0] OP_POOL       = 4'h7;
   localparam logic [3:0] OP_FC         = 4'h8;
   localparam logic [3:0] OP_SIGMOID    = 4'h9;
   localparam logic [3:0] OP_MIN        = OP_CMVN;
   localparam logic [3:0] OP_MAX        = OP_SIGMOID;

   // Response status codes
   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_TIMEOUT = 2'b01;
   localparam logic [1:0] ST_ILLEGAL = 2'b10;

   typedef enum logic [1:0] {
      SEQ_IDLE,
      SEQ_ISSUE,
      SEQ_WAIT,
      SEQ_RESP
   } seq_state_t;

   function automatic logic op_is_legal(input logic [3:0] op);
      return (op >= OP_MIN) && (op <= OP_MAX);
   endfunction

endpackage

// File: rtl/kws_cmd_fifo.sv
// kws_cmd_fifo: synchronous FIFO with occupancy count. No write-to-read
// bypass: a word written this cycle is visible at the head next cycle.
module kws_cmd_fifo
   import kws_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage array; pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/kws_cmd_sequencer.sv
// kws_cmd_sequencer: issues queued host opcodes to the layer-control FSM one
// at a time, holds the opcode for the whole run, waits for done or timeout
// and returns one status response per command.
// Optional macro KWS_SEQ_CYCLE_COUNT_EN adds the resp_cycles output.
module kws_cmd_sequencer
   import kws_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned CW      = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [3:0]               cmd_opcode,
   output logic                     fsm_start,
   output logic [3:0]               fsm_opcode,
   input  logic                     fsm_done,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [3:0]               resp_opcode,
   output logic [1:0]               resp_status,
   output logic                     busy,
`ifdef KWS_SEQ_CYCLE_COUNT_EN
   output logic [CW-1:0]            resp_cycles,
`endif
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

   seq_state_t    state;
   seq_state_t    state_n;
   logic          rst_done;
   logic          fifo_full;
   logic          fifo_empty;
   logic [3:0]    head;
   logic          push;
   logic          pop;
   logic          wait_exit;
   logic [CW-1:0] counter;
   logic [CW-1:0] counter_n;
   logic [3:0]    fsm_opcode_n;
   logic [3:0]    resp_opcode_n;
   logic [1:0]    resp_status_n;

   assign cmd_ready = rst_done && !fifo_full;
   assign push      = cmd_valid && cmd_ready;
   assign wait_exit = (state == SEQ_WAIT) && (state_n == SEQ_RESP);

   kws_cmd_fifo #(
      .DEPTH (DEPTH),
      .W     (4)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (cmd_opcode),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= SEQ_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state logic and FIFO pop decision
   always_comb begin
      state_n = state;
      pop     = 1'b0;
      unique case (state)
         SEQ_IDLE: begin
            if (!fifo_empty && !resp_valid) begin
               pop     = 1'b1;
               state_n = op_is_legal(head) ? SEQ_ISSUE : SEQ_RESP;
            end
         end
         SEQ_ISSUE: state_n = SEQ_WAIT;
         SEQ_WAIT: begin
            if (fsm_done || (counter == LAST_WAIT)) begin
               state_n = SEQ_RESP;
            end
         end
         SEQ_RESP: begin
            if (resp_ready) begin
               state_n = SEQ_IDLE;
            end
         end
         default: state_n = SEQ_IDLE;
      endcase
   end

   // Datapath next values: opcode latch, wait counter, response fields
   always_comb begin
      fsm_opcode_n  = fsm_opcode;
      resp_opcode_n = resp_opcode;
      resp_status_n = resp_status;
      counter_n     = counter;
      unique case (state)
         SEQ_IDLE: begin
            if (pop) begin
               if (op_is_legal(head)) begin
                  fsm_opcode_n = head;
               end else begin
                  resp_opcode_n = head;
                  resp_status_n = ST_ILLEGAL;
               end
            end
         end
         SEQ_ISSUE: counter_n = '0;
         SEQ_WAIT: begin
            counter_n = counter + 1'b1;
            // done is tested first so it wins over a coincident timeout
            if (fsm_done) begin
               resp_opcode_n = fsm_opcode;
               resp_status_n = ST_OK;
            end else if (counter == LAST_WAIT) begin
               resp_opcode_n = fsm_opcode;
               resp_status_n = ST_TIMEOUT;
            end
         end
         default: ;
      endcase
   end

   // Registered outputs, decoded from the upcoming state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rst_done    <= 1'b0;
         counter     <= '0;
         fsm_start   <= 1'b0;
         fsm_opcode  <= '0;
         resp_valid  <= 1'b0;
         resp_opcode <= '0;
         resp_status <= ST_OK;
         busy        <= 1'b0;
      end else begin
         rst_done    <= 1'b1;
         counter     <= counter_n;
         fsm_start   <= (state_n == SEQ_ISSUE);
         fsm_opcode  <= fsm_opcode_n;
         resp_valid  <= (state_n == SEQ_RESP);
         resp_opcode <= resp_opcode_n;
         resp_status <= resp_status_n;
         busy        <= (state_n == SEQ_ISSUE) || (state_n == SEQ_WAIT);
      end
   end

`ifdef KWS_SEQ_CYCLE_COUNT_EN
   // Capture the number of WAIT cycles spent; illegal commands report zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_cycles <= '0;
      end else if (wait_exit) begin
         resp_cycles <= counter + 1'b1;
      end else if (pop && !op_is_legal(head)) begin
         resp_cycles <= '0;
      end
   end
`else
   logic unused_wait_exit;
   assign unused_wait_exit = wait_exit;
`endif

endmodule

// File: tb/tb_kws_cmd_sequencer.sv
// tb_kws_cmd_sequencer: directed vector table, back-pressure and reset
// sequences, then randomized traffic against a transaction-level model.
module tb_kws_cmd_sequencer;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned TIMEOUT = 16;
   localparam int unsigned CW      = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [3:0]    cmd_opcode = 4'h0;
   logic          fsm_start;
   logic [3:0]    fsm_opcode;
   logic          fsm_done = 1'b0;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic [3:0]    resp_opcode;
   logic [1:0]    resp_status;
   logic          busy;
   logic [2:0]    fifo_count;
`ifdef KWS_SEQ_CYCLE_COUNT_EN
   logic [CW-1:0] resp_cycles;
`endif

   kws_cmd_sequencer #(
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT),
      .CW      (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_opcode  (cmd_opcode),
      .fsm_start   (fsm_start),
      .fsm_opcode  (fsm_opcode),
      .fsm_done    (fsm_done),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_opcode (resp_opcode),
      .resp_status (resp_status),
      .busy        (busy),
`ifdef KWS_SEQ_CYCLE_COUNT_EN
      .resp_cycles (resp_cycles),
`endif
      .fifo_count  (fifo_count)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;

   // Transaction model: accepted commands in order, plus the one in flight
   logic [3:0] model_q[$];
   int         forced_dly = -1;   // -1 random, 0 never done, >0 fixed delay
   int         done_at = -1;
   bit         in_flight = 0;
   bit         resp_active = 0;
   bit         expect_drop = 0;
   logic [3:0] cur_op = 4'h0;
   int         cur_start = 0;
   int         cur_eff = 0;
   int         cur_d = 0;
   logic [3:0] exp_op = 4'h0;
   logic [1:0] exp_st = 2'b00;
   int         exp_cyc = 0;
   int         starts = 0;
   int         resps = 0;
   int         busy_cycles = 0;

   typedef struct {
      logic [3:0] op;
      int         dly;
      logic [1:0] st;
      int         lat;
      int         cycles;
      int         nstart;
   } vec_t;
   vec_t vecs[9];

   logic [3:0] bp_ops[5];
   int         p, s0, b0, lat, accepts, r0;
   bit         got, acc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic bit legal(input logic [3:0] op);
      return (op >= 4'd3) && (op <= 4'd9);
   endfunction

   // One clock: commit this cycle's handshakes, advance, then observe
   task automatic cycle();
      if (cmd_valid && cmd_ready) model_q.push_back(cmd_opcode);
      if (resp_valid && resp_ready) begin
         if (model_q.size() > 0) void'(model_q.pop_front());
         in_flight   = 0;
         resp_active = 0;
         expect_drop = 1;
         resps++;
      end
      @(posedge clk);
      #1;
      cyc++;
      fsm_done = (cyc == done_at);
      if (expect_drop) begin
         chk("resp_drop", resp_valid, 1'b0);
         expect_drop = 0;
      end
      if (fsm_start) begin
         starts++;
         chk("start_overlap", in_flight, 1'b0);
         chk("start_qsize", model_q.size() > 0, 1'b1);
         if (model_q.size() > 0) begin
            chk("start_legal", legal(model_q[0]), 1'b1);
            chk("start_op", fsm_opcode, model_q[0]);
            cur_op = model_q[0];
         end
         in_flight = 1;
         cur_start = cyc;
         if (forced_dly >= 0) cur_d = forced_dly;
         else cur_d = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, TIMEOUT + 3));
         done_at = (cur_d > 0) ? cyc + cur_d : -1;
         cur_eff = (cur_d > 0 && cur_d <= int'(TIMEOUT)) ? cur_d : int'(TIMEOUT);
      end
      if (busy) busy_cycles++;
      chk("busy", busy, in_flight && (cyc <= cur_start + cur_eff));
      if (in_flight) chk("fsm_op_hold", fsm_opcode, cur_op);
      if (resp_valid) begin
         if (!resp_active) begin
            resp_active = 1;
            if (in_flight) begin
               exp_op  = cur_op;
               exp_st  = (cur_d > 0 && cur_d <= int'(TIMEOUT)) ? 2'b00 : 2'b01;
               exp_cyc = cur_eff;
               chk("resp_time", cyc, cur_start + cur_eff + 1);
            end else begin
               chk("resp_qsize", model_q.size() > 0, 1'b1);
               exp_op  = (model_q.size() > 0) ? model_q[0] : 4'h0;
               exp_st  = 2'b10;
               exp_cyc = 0;
               chk("illegal_front", legal(exp_op), 1'b0);
            end
         end
         chk("resp_op", resp_opcode, exp_op);
         chk("resp_status", resp_status, exp_st);
`ifdef KWS_SEQ_CYCLE_COUNT_EN
         chk("resp_cycles", resp_cycles, exp_cyc);
`endif
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_fsm_start"}, fsm_start, 1'b0);
      chk({tag, "_fsm_opcode"}, fsm_opcode, 4'h0);
      chk({tag, "_resp_valid"}, resp_valid, 1'b0);
      chk({tag, "_resp_opcode"}, resp_opcode, 4'h0);
      chk({tag, "_resp_status"}, resp_status, 2'b00);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_fifo_count"}, fifo_count, 3'd0);
`ifdef KWS_SEQ_CYCLE_COUNT_EN
      chk({tag, "_resp_cycles"}, resp_cycles, 0);
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{4'h9,  5, 2'b00,  8,  5, 1};
      vecs[1] = '{4'h5,  0, 2'b01, 19, 16, 1};
      vecs[2] = '{4'h2,  0, 2'b10,  2,  0, 0};
      vecs[3] = '{4'hA,  0, 2'b10,  2,  0, 0};
      vecs[4] = '{4'h3, 16, 2'b00, 19, 16, 1};
      vecs[5] = '{4'h4,  1, 2'b00,  4,  1, 1};
      vecs[6] = '{4'h6, 17, 2'b01, 19, 16, 1};
      vecs[7] = '{4'h0,  0, 2'b10,  2,  0, 0};
      vecs[8] = '{4'hF,  0, 2'b10,  2,  0, 0};
      bp_ops[0] = 4'h4; bp_ops[1] = 4'h5; bp_ops[2] = 4'h6;
      bp_ops[3] = 4'h7; bp_ops[4] = 4'h8;

      // Reset values
      #2 rst = 1'b1;
      #1;
      chk_reset_outputs("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      cycle();
      chk("ready_after_reset", cmd_ready, 1'b1);

      // Directed vector table: single command, fixed done delay
      resp_ready = 1'b1;
      foreach (vecs[i]) begin
         forced_dly = vecs[i].dly;
         s0 = starts;
         b0 = busy_cycles;
         cmd_valid  = 1'b1;
         cmd_opcode = vecs[i].op;
         p = cyc;
         cycle();
         cmd_valid = 1'b0;
         got = 0;
         lat = 0;
         for (int k = 0; k < 40 && !got; k++) begin
            cycle();
            if (resp_valid) begin
               got = 1;
               lat = cyc - p;
               chk("vec_op", resp_opcode, vecs[i].op);
               chk("vec_status", resp_status, vecs[i].st);
`ifdef KWS_SEQ_CYCLE_COUNT_EN
               chk("vec_cycles", resp_cycles, vecs[i].cycles);
`endif
            end
         end
         chk("vec_latency", lat, vecs[i].lat);
         repeat (3) cycle();
         chk("vec_starts", starts - s0, vecs[i].nstart);
         chk("vec_busy_cycles", busy_cycles - b0, (vecs[i].nstart != 0) ? vecs[i].lat - 2 : 0);
      end

      // Back-pressure: first response stalls, FIFO fills, order preserved
      resp_ready = 1'b0;
      forced_dly = 2;
      cmd_valid  = 1'b1;
      cmd_opcode = 4'h3;
      cycle();
      cmd_valid = 1'b0;
      for (int k = 0; k < 20 && !resp_valid; k++) cycle();
      chk("bp_first_resp", resp_valid, 1'b1);
      r0 = resps;
      s0 = starts;
      accepts = 0;
      for (int n = 0; n < 12 && accepts < 4; n++) begin
         cmd_valid  = 1'b1;
         cmd_opcode = bp_ops[accepts];
         if (cmd_ready) accepts++;
         cycle();
      end
      cmd_opcode = bp_ops[4];
      chk("bp_ready_low", cmd_ready, 1'b0);
      chk("bp_count_full", fifo_count, 3'd4);
      repeat (5) cycle();
      chk("bp_ready_held", cmd_ready, 1'b0);
      chk("bp_no_start", starts - s0, 0);
      forced_dly = 3;
      resp_ready = 1'b1;
      for (int n = 0; n < 300 && !(cmd_valid == 1'b0 && model_q.size() == 0 && !in_flight); n++) begin
         acc = cmd_valid && cmd_ready;
         cycle();
         if (acc) cmd_valid = 1'b0;
      end
      chk("bp_responses", resps - r0, 6);

      // Reset during WAIT with a queued command; late done is ignored
      forced_dly = 0;
      cmd_valid  = 1'b1;
      cmd_opcode = 4'h5;
      cycle();
      cmd_opcode = 4'h7;
      cycle();
      cmd_valid = 1'b0;
      repeat (8) cycle();
      chk("pre_reset_busy", busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk_reset_outputs("midrun");
      @(posedge clk);
      #1 rst = 1'b0;
      cyc++;
      model_q.delete();
      in_flight   = 0;
      resp_active = 0;
      expect_drop = 0;
      s0 = starts;
      done_at = cyc + 2;
      repeat (6) cycle();
      chk("post_reset_starts", starts - s0, 0);
      chk("post_reset_resp", resp_valid, 1'b0);
      chk("post_reset_count", fifo_count, 3'd0);

      // Randomized traffic against the model
      forced_dly = -1;
      for (int n = 0; n < 1500; n++) begin
         cmd_valid  = ($urandom_range(0, 1) == 1);
         cmd_opcode = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(3, 9));
         resp_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      cmd_valid  = 1'b0;
      resp_ready = 1'b1;
      for (int n = 0; n < 2000 && (model_q.size() > 0 || in_flight); n++) cycle();
      chk("drain_empty", model_q.size(), 0);
      chk("drain_count", fifo_count, 3'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule

// File: doc/kws_cmd_sequencer.md
Name: kws_cmd_sequencer

Overview:
- Command initiator that drives the layer-control FSM's start/opcode/done handshake.
- The host pushes opcodes into a small FIFO. The sequencer issues them one at a time and holds the opcode stable for the whole run, because the FSM re-reads opcode in its RELU and BATCH_NORM states.
- It waits for the done pulse or a timeout, then returns one status response per command.
- Sits between the host/CSR layer and the layer-control FSM.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, at least 2.
- TIMEOUT, 1024, maximum WAIT cycles before the command is declared timed out; at least 2.
- CW, 16, width of the wait/cycle counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  FIFO not full.
- cmd_opcode  in  4  opcode to issue.
- fsm_start  out  1  one-cycle start pulse to the FSM.
- fsm_opcode  out  4  opcode to the FSM, held for the full run.
- fsm_done  in  1  done pulse from the FSM.
- resp_valid  out  1  response available.
- resp_ready  in  1  host accepts the response.
- resp_opcode  out  4  opcode this response belongs to.
- resp_status  out  2  00 OK, 01 TIMEOUT, 10 ILLEGAL.
- busy  out  1  high in ISSUE or WAIT.
- fifo_count  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, clears immediately, including mid-run):
  - FIFO emptied, state IDLE, counter 0.
  - fsm_start=0, fsm_opcode=0, resp_valid=0, resp_opcode=0, resp_status=00, busy=0.
  - cmd_ready=1 from the first clock after reset deasserts.
- FIFO:
  - A push occurs when cmd_valid && cmd_ready. cmd_ready = (count != DEPTH).
  - There is no bypass: a command pushed in cycle N can be popped no earlier than cycle N+1.
  - Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- State machine (all outputs registered):
  - IDLE: if the FIFO is non-empty and resp_valid=0, pop the head.
    - Legal opcode (4'h3..4'h9): latch it into fsm_opcode, go to ISSUE.
    - Otherwise: load resp_opcode and status 10, go to RESP. fsm_start is never pulsed.
  - ISSUE: fsm_start=1 for exactly this cycle; clear counter; go to WAIT.
  - WAIT: fsm_start=0 and counter increments each cycle.
    - fsm_done=1: status 00, go to RESP.
    - Else if counter == TIMEOUT-1: status 01, go to RESP.
    - If done arrives in the same cycle as the timeout, OK wins.
  - RESP: resp_valid=1 with resp_opcode/resp_status stable until resp_ready. On the handshake, resp_valid drops next cycle and the state goes to IDLE.
- fsm_opcode stays driven from ISSUE until the next pop; it is not cleared in RESP.
- fsm_done outside WAIT is ignored.
- Latency:
  - Push at cycle 0 into an empty, idle sequencer gives pop at cycle 1 and fsm_start high at cycle 2.
  - A done pulse sampled at cycle k gives resp_valid at cycle k+1.
- Back-to-back: minimum start-to-start spacing is 4 cycles (ISSUE, WAIT, RESP, IDLE) with resp_ready tied high.
- busy = (state==ISSUE || state==WAIT).

Optional Feature:
- KWS_SEQ_CYCLE_COUNT_EN:
  - Defined: adds output resp_cycles [CW-1:0], the WAIT cycle count captured on the transition to RESP.
    - ILLEGAL responses report 0.
    - Reset value 0; held stable alongside resp_valid.
  - Undefined: the port is absent and no capture register is built.

Decomposition:
- Package kws_pkg holds:
  - opcode constants OP_CMVN=4'h3 … OP_SIGMOID=4'h9, plus OP_MIN/OP_MAX.
  - status constants ST_OK/ST_TIMEOUT/ST_ILLEGAL.
  - sequencer state encodings.
- Sub-module kws_cmd_fifo: parametrised synchronous FIFO with count output, instantiated once.

Test Plan:
- Push 4'h9, fsm_done pulsed 5 cycles after start -> exactly one fsm_start pulse, fsm_opcode=9 held through WAIT, response {9, 00}.
- Push 4'h5 with no done (the FSM loops RELU/CNN/BN), TIMEOUT=16 -> resp {5, 01} at start+17; with the macro, resp_cycles=16.
- Push 4'h2 then 4'hA -> two {op, 10} responses, fsm_start never asserted, busy never high.
- Push 5 commands while resp_ready=0 and DEPTH=4 -> cmd_ready low after fourth accept; no second start until the first response is accepted; all responses in push order.
- Assert rst during WAIT -> outputs return to reset values immediately; FIFO empty; a late fsm_done is ignored.
- Same-cycle fsm_done and timeout at counter=TIMEOUT-1 -> status 00.
